// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: one bit per cycle over a shared 33-bit add/sub.
// Optional build macro MULDIV_EARLY_OUT_EN lets trivial operations skip the iteration phase.
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    if (XLEN != 32 || CNT_W != $clog2(XLEN)) begin : g_param_check
        $error("muldiv_seq supports only XLEN=32 with CNT_W=5");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [2:0]        op_reg;
    logic [XLEN-1:0]   a_reg, b_reg, acc_reg, q_reg, result_reg;
    logic              a_neg_reg, b_neg_reg, dz_reg, ovf_reg, mz_reg;

    logic              accept, a_signed, b_signed, a_neg_in, b_neg_in;
    logic              dz_in, ovf_in, mz_in, early;
    logic [XLEN-1:0]   a_mag_in, b_mag_in, mul_addend;
    logic [XLEN:0]     addsub_a, addsub_b, addsub_sum;
    logic [XLEN-1:0]   acc_step, q_step, fix_val, rem_mag;
    logic [2*XLEN-1:0] prod_mag, prod_sgn;

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign busy      = (state_reg != S_IDLE);
    assign result    = result_reg;
    assign accept    = in_ready & in_valid & ~flush;

    // MULHU/DIVU/REMU are fully unsigned; MULHSU keeps only srcA signed.
    assign a_signed = ~(funct3 == 3'b011 || funct3 == 3'b101 || funct3 == 3'b111);
    assign b_signed = (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110);
    assign a_neg_in = a_signed & srcA[XLEN-1];
    assign b_neg_in = b_signed & srcB[XLEN-1];
    assign a_mag_in = a_neg_in ? -srcA : srcA;
    assign b_mag_in = b_neg_in ? -srcB : srcB;

    assign dz_in  = funct3[2] & (srcB == '0);
    assign ovf_in = funct3[2] & ~funct3[0] & (srcA == {1'b1, {(XLEN-1){1'b0}}}) & (&srcB);
    assign mz_in  = ~funct3[2] & ((srcA == '0) | (srcB == '0));

`ifdef MULDIV_EARLY_OUT_EN
    assign early = dz_in | ovf_in | mz_in;
`else
    assign early = 1'b0;
`endif

    for (genvar gi = 0; gi < XLEN; gi++) begin : g_mul_addend
        assign mul_addend[gi] = a_reg[gi] & q_reg[0];
    end

    // Multiply: {acc,q} is the product shifting right. Divide: q holds the dividend
    // shifting left into acc (the remainder), quotient bits entering at q[0].
    always_comb begin
        addsub_a   = op_reg[2] ? {acc_reg, q_reg[XLEN-1]} : {1'b0, acc_reg};
        addsub_b   = op_reg[2] ? {1'b0, b_reg} : {1'b0, mul_addend};
        addsub_sum = op_reg[2] ? (addsub_a - addsub_b) : (addsub_a + addsub_b);
        if (op_reg[2]) begin
            if (!addsub_sum[XLEN]) begin
                acc_step = addsub_sum[XLEN-1:0];
                q_step   = {q_reg[XLEN-2:0], 1'b1};
            end else begin
                acc_step = addsub_a[XLEN-1:0];
                q_step   = {q_reg[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = addsub_sum[XLEN:1];
            q_step   = {addsub_sum[0], q_reg[XLEN-1:1]};
        end
    end

    always_comb begin
        prod_mag = {acc_reg, q_reg};
        prod_sgn = (a_neg_reg ^ b_neg_reg) ? -prod_mag : prod_mag;
        // With a zero divisor the remainder is the dividend, also on the early-out path.
        rem_mag  = dz_reg ? a_reg : acc_reg;
        fix_val  = '0;
        case (op_reg)
            3'b000:                 fix_val = prod_sgn[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_sgn[2*XLEN-1:XLEN];
            3'b100, 3'b101: begin
                if (ovf_reg)     fix_val = {1'b1, {(XLEN-1){1'b0}}};
                else if (dz_reg) fix_val = '1;
                else             fix_val = (a_neg_reg ^ b_neg_reg) ? -q_reg : q_reg;
            end
            default: begin
                if (ovf_reg) fix_val = '0;
                else         fix_val = a_neg_reg ? -rem_mag : rem_mag;
            end
        endcase
        if (mz_reg) fix_val = '0;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (in_valid) state_next = early ? S_FIX : S_CALC;
            S_CALC: if (cnt_reg == '0) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            default: if (out_ready) state_next = S_IDLE;
        endcase
        if (flush) state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            acc_reg    <= '0;
            q_reg      <= '0;
            a_neg_reg  <= 1'b0;
            b_neg_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
            mz_reg     <= 1'b0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                cnt_reg   <= {CNT_W{1'b1}};
                op_reg    <= funct3;
                a_reg     <= a_mag_in;
                b_reg     <= b_mag_in;
                acc_reg   <= '0;
                q_reg     <= funct3[2] ? a_mag_in : b_mag_in;
                a_neg_reg <= a_neg_in;
                b_neg_reg <= b_neg_in;
                dz_reg    <= dz_in;
                ovf_reg   <= ovf_in;
                mz_reg    <= mz_in;
            end else if (state_reg == S_CALC) begin
                acc_reg <= acc_step;
                q_reg   <= q_step;
                if (cnt_reg != '0) cnt_reg <= cnt_reg - CNT_W'(1);
            end
            if (state_reg == S_FIX && !flush) result_reg <= fix_val;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M vectors, latency, hold, flush and reset checks.
module tb_muldiv_seq;

    localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]  funct3;
    logic [31:0] srcA, srcB, result;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;

    muldiv_seq dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .srcA(srcA), .srcB(srcB), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every result handshake pops one expected value.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got result %h, required no output", result);
            end else begin
                e = exp_q.pop_front();
                chk(e.name, result, e.val);
            end
        end
    end

    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        step();
        funct3   = f3;
        srcA     = a;
        srcB     = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        funct3   = 3'($urandom);
        srcA     = $urandom;
        srcB     = $urandom;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv, input int exp_lat,
                          input bit hold);
        int n;
        bit busy_ok;
        out_ready = !hold;
        start_op(f3, a, b);
        exp_q.push_back('{name, expv});
        n = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end while (out_valid !== 1'b1 && n < 60);
        chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        chk({name, "_busy"}, 32'(busy_ok), 32'd1);
        if (hold) begin
            repeat (10) begin
                @(negedge clk);
                chk({name, "_hold_valid"}, 32'(out_valid), 32'd1);
                chk({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
                chk({name, "_hold_result"}, result, expv);
            end
            step();
            out_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        chk({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
        chk({name, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit seen_valid;
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        funct3 = '0; srcA = '0; srcB = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", result, 32'd0);
        step();
        reset = 1'b0;

        run_op("mul_7_m3",        OP_MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
        run_op("mulhu_m1_m1",     OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
        run_op("mulh_m1_m1",      OP_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 34, 0);
        run_op("mulhsu_m1_2",     OP_MULHSU, 32'hFFFFFFFF,   32'd2,        32'hFFFFFFFF, 34, 0);
        run_op("mulhu_8000_2",    OP_MULHU,  32'h80000000,   32'd2,        32'h00000001, 34, 0);
        run_op("div_m7_2",        OP_DIV,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 34, 0);
        run_op("rem_m7_2",        OP_REM,    32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 34, 0);
        run_op("div_7_m2",        OP_DIV,    32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 34, 0);
        run_op("rem_7_m2",        OP_REM,    32'd7,          32'hFFFFFFFE, 32'h00000001, 34, 0);
        run_op("divu_100_7",      OP_DIVU,   32'd100,        32'd7,        32'd14,       34, 0);
        run_op("remu_100_7",      OP_REMU,   32'd100,        32'd7,        32'd2,        34, 0);
        run_op("divu_5_0",        OP_DIVU,   32'd5,          32'd0,        32'hFFFFFFFF, EO_LAT, 0);
        run_op("remu_5_0",        OP_REMU,   32'd5,          32'd0,        32'd5,        EO_LAT, 0);
        run_op("div_m6_0",        OP_DIV,    32'hFFFFFFFA,   32'd0,        32'hFFFFFFFF, EO_LAT, 0);
        run_op("rem_m6_0",        OP_REM,    32'hFFFFFFFA,   32'd0,        32'hFFFFFFFA, EO_LAT, 0);
        run_op("div_ovf",         OP_DIV,    32'h80000000,   32'hFFFFFFFF, 32'h80000000, EO_LAT, 0);
        run_op("rem_ovf",         OP_REM,    32'h80000000,   32'hFFFFFFFF, 32'h00000000, EO_LAT, 0);
        run_op("mul_0_5",         OP_MUL,    32'd0,          32'd5,        32'h00000000, EO_LAT, 0);
        run_op("mul_hold",        OP_MUL,    32'd123,        32'd456,      32'h0000DB18, 34, 1);

        // Flush during cycle 15 of a divide: no result must ever appear.
        start_op(OP_DIV, 32'd1000, 32'd7);
        repeat (14) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        seen_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        chk("flush_no_valid", 32'(seen_valid), 32'd0);
        run_op("mul_3_4", OP_MUL, 32'd3, 32'd4, 32'd12, 34, 0);

        // Flush wins over a simultaneous request.
        step();
        funct3 = OP_MUL; srcA = 32'd1; srcB = 32'd1;
        in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("flush_vs_accept_busy", 32'(busy), 32'd0);

        // Reset in the middle of CALC.
        start_op(OP_MUL, 32'd9, 32'd9);
        repeat (8) step();
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", result, 32'd0);
        reset = 1'b0;
        run_op("remu_17_5", OP_REMU, 32'd17, 32'd5, 32'd2, 34, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
